hangman_word_engine: RTL and testbench

Parametrised secret-word store and guess evaluator for the hangman game datapath. It loads a word one character at a time, then evaluates each guessed letter by scanning every stored position. Per guess it updates a per-position reveal mask, hit/miss and remaining-letter counters, and win/lose status. A random-access display port feeds the blank/letter renderer. It replaces the fixed 5-bit, single-counter memory datapath with a handshaked, width/depth-configurable engine that adds repeat-guess detection.

---
 rtl/hangman_pkg.sv | 16 +
 rtl/hangman_word_store.sv | 43 ++++
 rtl/hangman_word_engine.sv | 168 ++++++++++++++++
 tb/tb_hangman_word_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman word engine.
// Holds the FSM state enum, default char width and the blank code.
package hangman_pkg;

    typedef enum logic [2:0] {
        LOAD,
        IDLE,
        SCAN,
        REPORT,
        DONE
    } state_t;

    localparam int CHAR_W_DEF = 5;
    localparam int BLANK_CHAR = 0;

endpackage

// File: rtl/hangman_word_store.sv
// Secret-word register file: MAX_LEN x CHAR_W, one sync write port,
// two combinational read ports (a: scan, b: display); sync clear on resetn.
module word_store
    import hangman_pkg::*;
#(
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int MAX_LEN = 16,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [LW-1:0]     waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [LW-1:0]     raddr_a,
    output logic [CHAR_W-1:0] rdata_a,
    input  logic [LW-1:0]     raddr_b,
    output logic [CHAR_W-1:0] rdata_b
);

    logic [CHAR_W-1:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (resetn) begin
                mem[i] <= CHAR_W'(BLANK_CHAR);
            end else if (we && waddr == LW'(i)) begin
                mem[i] <= wdata;
            end
        end
    end

    // Address decode by compare so out-of-range addresses read blank.
    always_comb begin
        rdata_a = CHAR_W'(BLANK_CHAR);
        rdata_b = CHAR_W'(BLANK_CHAR);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (raddr_a == LW'(i)) rdata_a = mem[i];
            if (raddr_b == LW'(i)) rdata_b = mem[i];
        end
    end

endmodule

// File: rtl/hangman_word_engine.sv
// Hangman secret-word engine: loads a word, scans each guess across it,
// tracks reveal mask, remain/miss counts, win/lose; plus display read port.
module hangman_word_engine
    import hangman_pkg::*;
#(
    parameter int CHAR_W     = CHAR_W_DEF,
    parameter int MAX_LEN    = 16,
    parameter int MAX_MISSES = 6,
    parameter int LW         = $clog2(MAX_LEN + 1),
    parameter int MW         = $clog2(MAX_MISSES + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ld,
    input  logic [CHAR_W-1:0]  char_in,
    input  logic               ld_done,
    input  logic               guess_valid,
    input  logic [CHAR_W-1:0]  guess,
    output logic               guess_ready,
    output logic               result_valid,
    output logic               hit,
    output logic [LW-1:0]      hit_count,
    output logic               repeat_guess,
    output logic [LW-1:0]      remain,
    output logic [MW-1:0]      misses,
    output logic               won,
    output logic               lost,
    output logic [LW-1:0]      length,
    output logic [MAX_LEN-1:0] reveal_mask,
    input  logic [LW-1:0]      disp_addr,
    output logic [CHAR_W-1:0]  disp_char,
    output logic               disp_shown
);

    state_t state, state_n;

    logic [(1<<CHAR_W)-1:0] bitmap;
    logic [CHAR_W-1:0]      guess_q;
    logic [LW-1:0]          idx;
    logic [CHAR_W-1:0]      scan_char;
    logic [CHAR_W-1:0]      store_char;
    logic [MAX_LEN-1:0]     mask_at_idx;
    logic [MAX_LEN-1:0]     mask_at_disp;

    logic          we;
    logic [LW-1:0] len_after;
    logic          accept;
    logic          is_rpt;
    logic          last;
    logic          match;
    logic [LW-1:0] remain_n;
    logic [MW-1:0] misses_n;
    logic          won_n;
    logic          lost_n;

    word_store #(
        .CHAR_W (CHAR_W),
        .MAX_LEN(MAX_LEN),
        .LW     (LW)
    ) u_store (
        .clk    (clk),
        .resetn (resetn),
        .we     (we),
        .waddr  (length),
        .wdata  (char_in),
        .raddr_a(idx),
        .rdata_a(scan_char),
        .raddr_b(disp_addr),
        .rdata_b(store_char)
    );

    assign guess_ready  = (state == IDLE);
    assign result_valid = (state == REPORT);
    assign hit          = (hit_count != '0) && !repeat_guess;

    assign we        = (state == LOAD) && ld && (length < LW'(MAX_LEN));
    assign len_after = we ? length + LW'(1) : length;
    assign accept    = guess_valid && guess_ready;
    assign is_rpt    = (guess == CHAR_W'(BLANK_CHAR)) || bitmap[guess];
    assign last      = (idx == length - LW'(1));

    // Only still-hidden positions count, so remain can never underflow.
    assign mask_at_idx = reveal_mask >> idx;
    assign match       = (scan_char == guess_q) && !mask_at_idx[0];

    always_comb begin
        remain_n = remain;
        misses_n = misses;
        if (!repeat_guess) begin
            remain_n = remain - hit_count;
            if (hit_count == '0 && misses != MW'(MAX_MISSES))
                misses_n = misses + MW'(1);
        end
        won_n  = (remain_n == '0);
        lost_n = (misses_n == MW'(MAX_MISSES));
    end

    assign mask_at_disp = reveal_mask >> disp_addr;
    assign disp_char  = (disp_addr < length) ? store_char
                                             : CHAR_W'(BLANK_CHAR);
    assign disp_shown = (disp_addr < length) && mask_at_disp[0];

    always_ff @(posedge clk) begin
        if (resetn) state <= LOAD;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    if (ld_done && len_after != '0) state_n = IDLE;
            IDLE:    if (accept) state_n = is_rpt ? REPORT : SCAN;
            SCAN:    if (last) state_n = REPORT;
            REPORT:  state_n = (won_n || lost_n) ? DONE : IDLE;
            DONE:    state_n = DONE;
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            length       <= '0;
            remain       <= '0;
            misses       <= '0;
            hit_count    <= '0;
            reveal_mask  <= '0;
            bitmap       <= '0;
            guess_q      <= '0;
            idx          <= '0;
            repeat_guess <= 1'b0;
            won          <= 1'b0;
            lost         <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    length <= len_after;
                    if (ld_done && len_after != '0) remain <= len_after;
                end
                IDLE: begin
                    if (accept) begin
                        repeat_guess <= is_rpt;
                        if (!is_rpt) begin
                            bitmap[guess] <= 1'b1;
                            guess_q       <= guess;
                            hit_count     <= '0;
                            idx           <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (match) begin
                        reveal_mask <= reveal_mask | (MAX_LEN'(1) << idx);
                        hit_count   <= hit_count + LW'(1);
                    end
                    idx <= idx + LW'(1);
                end
                REPORT: begin
                    remain <= remain_n;
                    misses <= misses_n;
                    won    <= won_n;
                    lost   <= lost_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hangman_word_engine.sv
// Self-checking bench for hangman_word_engine: directed guesses with
// expected results queued and checked by an independent result monitor.
module tb_hangman_word_engine;

    localparam int CW = 5;
    localparam int ML = 16;
    localparam int MM = 6;
    localparam int LW = 5;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ld;
    logic [CW-1:0] char_in;
    logic          ld_done;
    logic          guess_valid;
    logic [CW-1:0] guess;
    logic          guess_ready;
    logic          result_valid;
    logic          hit;
    logic [LW-1:0] hit_count;
    logic          rpt;
    logic [LW-1:0] remain;
    logic [MW-1:0] misses;
    logic          won;
    logic          lost;
    logic [LW-1:0] length;
    logic [ML-1:0] reveal_mask;
    logic [LW-1:0] disp_addr;
    logic [CW-1:0] disp_char;
    logic          disp_shown;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic          h;
        int            hc;
        logic          r;
        logic [ML-1:0] m;
    } exp_t;

    exp_t exp_q[$];

    hangman_word_engine #(
        .CHAR_W    (CW),
        .MAX_LEN   (ML),
        .MAX_MISSES(MM)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ld          (ld),
        .char_in     (char_in),
        .ld_done     (ld_done),
        .guess_valid (guess_valid),
        .guess       (guess),
        .guess_ready (guess_ready),
        .result_valid(result_valid),
        .hit         (hit),
        .hit_count   (hit_count),
        .repeat_guess(rpt),
        .remain      (remain),
        .misses      (misses),
        .won         (won),
        .lost        (lost),
        .length      (length),
        .reveal_mask (reveal_mask),
        .disp_addr   (disp_addr),
        .disp_char   (disp_char),
        .disp_shown  (disp_shown)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, longint act, longint want);
        checks++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, want);
    endfunction

    // Result monitor: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got result_valid=1 expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_hit", hit, e.h);
                chk("res_repeat", rpt, e.r);
                chk("res_mask", reveal_mask, e.m);
                if (e.hc >= 0) chk("res_hit_count", hit_count, e.hc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ld = 0; ld_done = 0; guess_valid = 0;
        resetn = 1;
        tick();
        resetn = 0;
    endtask

    task automatic ld_char(input int c);
        ld = 1;
        char_in = CW'(c);
        tick();
        ld = 0;
    endtask

    task automatic finish_load();
        ld_done = 1;
        tick();
        ld_done = 0;
    endtask

    task automatic do_guess(input int g, input logic eh, input int ehc,
                            input logic er, input logic [ML-1:0] em,
                            input int elat);
        exp_t e;
        int n;
        n = 0;
        while (!guess_ready && n < 50) begin
            tick();
            n++;
        end
        if (!guess_ready) begin
            chk("guess_ready_wait", 0, 1);
            return;
        end
        e.h = eh; e.hc = ehc; e.r = er; e.m = em;
        exp_q.push_back(e);
        guess_valid = 1;
        guess = CW'(g);
        tick();
        guess_valid = 0;
        n = 0;
        while (!result_valid && n < 100) begin
            tick();
            n++;
        end
        chk("result_latency", n, elat);
        tick();
    endtask

    task automatic probe(input int a, input int ec, input int es);
        disp_addr = LW'(a);
        #1;
        chk("disp_char", disp_char, ec);
        chk("disp_shown", disp_shown, es);
    endtask

    initial begin
        resetn = 1; ld = 0; ld_done = 0; char_in = 0;
        guess_valid = 0; guess = 0; disp_addr = 0;
        tick();
        chk("rst_guess_ready", guess_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_length", length, 0);
        chk("rst_remain", remain, 0);
        chk("rst_misses", misses, 0);
        chk("rst_won", won, 0);
        chk("rst_lost", lost, 0);
        chk("rst_mask", reveal_mask, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_repeat", rpt, 0);
        chk("rst_disp_char", disp_char, 0);
        resetn = 0;

        // ld_done on an empty word stays in LOAD
        finish_load();
        chk("empty_done_ready", guess_ready, 0);
        chk("empty_done_length", length, 0);

        // word 3,1,20
        ld_char(3); ld_char(1); ld_char(20);
        finish_load();
        chk("w1_length", length, 3);
        chk("w1_remain", remain, 3);
        chk("w1_ready", guess_ready, 1);
        probe(1, 1, 0);
        probe(3, 0, 0);
        do_guess(1, 1, 1, 0, 16'h0002, 3);
        chk("w1_remain_g1", remain, 2);
        chk("w1_misses_g1", misses, 0);
        probe(1, 1, 1);
        do_guess(1, 0, -1, 1, 16'h0002, 0);
        chk("w1_remain_rep", remain, 2);
        chk("w1_misses_rep", misses, 0);
        do_guess(0, 0, -1, 1, 16'h0002, 0);
        chk("w1_misses_zero", misses, 0);
        do_guess(9, 0, 0, 0, 16'h0002, 3);
        chk("w1_misses_miss", misses, 1);
        chk("w1_remain_miss", remain, 2);
        chk("w1_won_miss", won, 0);

        // win: 2,15,15
        do_reset();
        ld_char(2); ld_char(15); ld_char(15);
        finish_load();
        do_guess(15, 1, 2, 0, 16'h0006, 3);
        chk("win_remain_1", remain, 1);
        do_guess(2, 1, 1, 0, 16'h0007, 3);
        chk("win_remain_0", remain, 0);
        chk("win_won", won, 1);
        chk("win_lost", lost, 0);
        chk("win_ready", guess_ready, 0);
        guess_valid = 1; guess = 20;
        repeat (5) tick();
        guess_valid = 0;
        chk("win_ready_after", guess_ready, 0);
        chk("win_misses", misses, 0);

        // lose: 1, guesses 2..7
        do_reset();
        ld_char(1);
        finish_load();
        for (int i = 2; i <= 7; i++) begin
            do_guess(i, 0, 0, 0, 16'h0000, 1);
            chk("lose_misses", misses, i - 1);
        end
        chk("lose_lost", lost, 1);
        chk("lose_won", won, 0);
        chk("lose_ready", guess_ready, 0);
        guess_valid = 1; guess = 8;
        repeat (5) tick();
        guess_valid = 0;
        chk("lose_misses_after", misses, MM);

        // overfill: MAX_LEN+1 loads
        do_reset();
        for (int i = 1; i <= ML + 1; i++) ld_char(i);
        chk("full_length", length, ML);
        finish_load();
        chk("full_ready", guess_ready, 1);
        chk("full_remain", remain, ML);
        probe(15, 16, 0);
        probe(16, 0, 0);

        // ld and ld_done together
        do_reset();
        ld_char(4); ld_char(5);
        ld = 1; ld_done = 1; char_in = 6;
        tick();
        ld = 0; ld_done = 0;
        chk("both_length", length, 3);
        chk("both_remain", remain, 3);
        chk("both_ready", guess_ready, 1);
        probe(2, 6, 0);

        // reset two cycles into SCAN
        guess_valid = 1; guess = 5;
        tick();
        guess_valid = 0;
        tick();
        resetn = 1;
        tick();
        resetn = 0;
        chk("mid_ready", guess_ready, 0);
        chk("mid_result_valid", result_valid, 0);
        chk("mid_length", length, 0);
        chk("mid_remain", remain, 0);
        chk("mid_mask", reveal_mask, 0);
        chk("mid_hit_count", hit_count, 0);
        chk("mid_repeat", rpt, 0);
        chk("mid_misses", misses, 0);
        probe(0, 0, 0);
        ld_char(7);
        chk("mid_load_len", length, 1);
        repeat (5) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
